// File: rtl/mem_access_stage.sv
// MEM stage: data-memory loads/stores against an internal synchronous RAM,
// owns the MEM/WB pipeline register and stalls upstream once per load.
module mem_access_stage #(
  parameter int unsigned ARQ       = 16,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned REGW      = 4,
  parameter              INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            ex_valid,
  input  logic [ARQ-1:0]  ex_alu_result,
  input  logic [ARQ-1:0]  ex_store_data,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_reg_write,
  output logic            stall,
  output logic            wb_valid,
  output logic [ARQ-1:0]  wb_alu_result,
  output logic [ARQ-1:0]  mem_result,
  output logic [REGW-1:0] wb_rd,
  output logic            wb_reg_write,
  output logic [ARQ-1:0]  wb_data,
  output logic            addr_err
);

  localparam int unsigned  ADDR_W  = $clog2(DEPTH);
  localparam logic [ARQ:0] DEPTH_W = (ARQ+1)'(DEPTH);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state_q, state_d;
  logic [ARQ-1:0]    ram [DEPTH];
  logic [ARQ-1:0]    rd_q;
  logic [ADDR_W-1:0] addr;
  logic              in_range, accept, is_load, is_store, is_both;
  logic              wb_mem_to_reg;
  logic [ARQ-1:0]    ld_alu_q;
  logic [REGW-1:0]   ld_rd_q;
  logic              ld_rw_q, ld_oob_q;

  // Decode the EX/MEM instruction: accept, stall, error pulse, next state
  always_comb begin
    addr     = ex_alu_result[ADDR_W-1:0];
    in_range = {1'b0, ex_alu_result} < DEPTH_W;
    accept   = !rst && en && ex_valid && (state_q == IDLE);
    is_both  = ex_mem_read && ex_mem_write;
    is_load  = ex_mem_read && !ex_mem_write;
    is_store = ex_mem_write && !ex_mem_read;
    stall    = accept && is_load;
    addr_err = accept && (is_both || ((ex_mem_read || ex_mem_write) && !in_range));
    state_d  = state_q;
    if (en) begin
      case (state_q)
        IDLE:    if (stall) state_d = LOAD;
        LOAD:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Single-port RAM: write at accept edge, registered read for loads
  always_ff @(posedge clk) begin
    if (accept && !is_both) begin
      if (is_store && in_range) ram[addr] <= ex_store_data;
      if (is_load)              rd_q      <= ram[addr];
    end
  end

  // MEM/WB register; load fields are captured at accept so the LOAD cycle
  // does not depend on upstream still holding EX/MEM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_alu_result <= '0;
      mem_result    <= '0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      ld_alu_q      <= '0;
      ld_rd_q       <= '0;
      ld_rw_q       <= 1'b0;
      ld_oob_q      <= 1'b0;
    end else if (en) begin
      wb_valid      <= 1'b0;
      wb_alu_result <= '0;
      mem_result    <= '0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && is_load) begin
            ld_alu_q <= ex_alu_result;
            ld_rd_q  <= ex_rd;
            ld_rw_q  <= ex_reg_write;
            ld_oob_q <= !in_range;
          end else if (accept) begin
            wb_valid      <= 1'b1;
            wb_alu_result <= ex_alu_result;
            wb_rd         <= ex_rd;
            wb_reg_write  <= ex_reg_write && !is_store;
          end
        end
        LOAD: begin
          wb_valid      <= 1'b1;
          wb_alu_result <= ld_alu_q;
          mem_result    <= ld_oob_q ? '0 : rd_q;
          wb_rd         <= ld_rd_q;
          wb_reg_write  <= ld_rw_q;
          wb_mem_to_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write-back data select
  always_comb begin
    wb_data = wb_mem_to_reg ? mem_result : wb_alu_result;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed steps plus randomized instructions
// checked against an array-based memory model.
module tb_mem_access_stage;

  logic        clk, rst, en;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [15:0] ex_alu_result, ex_store_data;
  logic [3:0]  ex_rd;
  logic        stall, wb_valid, wb_reg_write, addr_err;
  logic [15:0] wb_alu_result, mem_result, wb_data;
  logic [3:0]  wb_rd;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [15:0] mdl [256];

  mem_access_stage #(.ARQ(16), .DEPTH(256), .REGW(4), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .en(en), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .stall(stall), .wb_valid(wb_valid), .wb_alu_result(wb_alu_result),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction through the stage, with expectations from the model
  task automatic run(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                     input logic [3:0] rd, input logic mr, input logic mw, input logic rw);
    logic        e_stall, e_err, inr, ld, st;
    logic [15:0] e_mem;
    @(negedge clk);
    ex_valid = v; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
    ex_mem_read = mr; ex_mem_write = mw; ex_reg_write = rw;
    inr = (alu < 16'd256);
    ld  = mr && !mw;
    st  = mw && !mr;
    e_stall = v && ld;
    e_err   = v && ((mr && mw) || ((mr || mw) && !inr));
    e_mem   = (ld && inr) ? mdl[alu[7:0]] : 16'h0000;
    #1;
    chk("stall", stall, e_stall);
    chk("addr_err", addr_err, e_err);
    @(posedge clk); #1;
    if (v && st && inr) mdl[alu[7:0]] = sd;
    if (e_stall) begin
      chk("ld_bubble_valid", wb_valid, 0);
      chk("ld_bubble_rw", wb_reg_write, 0);
      chk("ld_stall_cycle2", stall, 0);
      @(posedge clk); #1;
    end
    if (v) begin
      chk("wb_valid", wb_valid, 1);
      chk("wb_rd", wb_rd, rd);
      chk("wb_reg_write", wb_reg_write, st ? 1'b0 : rw);
      chk("mem_result", mem_result, e_mem);
      chk("wb_alu_result", wb_alu_result, alu);
      chk("wb_data", wb_data, ld ? e_mem : alu);
    end else begin
      chk("bubble_valid", wb_valid, 0);
      chk("bubble_rw", wb_reg_write, 0);
    end
  endtask

  logic [15:0] q_data [$];
  logic [3:0]  q_rd [$];
  logic [15:0] exp_d [8];
  logic        en_b, adv, done;
  logic [15:0] a;

  initial begin
    rst = 1'b1; en = 1'b1;
    ex_valid = 0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0;
    ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mem_result", mem_result, 0);
    chk("rst_wb_alu", wb_alu_result, 0);
    chk("rst_wb_rw", wb_reg_write, 0);
    chk("rst_stall", stall, 0);
    chk("rst_addr_err", addr_err, 0);
    @(negedge clk); rst = 1'b0;

    // ALU pass-through
    run(1, 16'h00A5, 16'h0, 4'd3, 0, 0, 1);

    // Fill every RAM word so later loads have known contents
    for (int i = 0; i < 256; i++)
      run(1, 16'(i), 16'($urandom), 4'($urandom_range(0, 15)), 0, 1, 1);

    // Store then load the same address back-to-back
    run(1, 16'h0010, 16'hBEEF, 4'd1, 0, 1, 1);
    run(1, 16'h0010, 16'h0000, 4'd5, 1, 0, 1);
    chk("beef_readback", wb_data, 16'hBEEF);

    // Out-of-range accesses and illegal control
    run(1, 16'h0100, 16'h0000, 4'd2, 1, 0, 1);
    run(1, 16'h0200, 16'h1234, 4'd4, 0, 1, 0);
    run(1, 16'h0000, 16'h0000, 4'd6, 1, 0, 1);
    run(1, 16'h0020, 16'h5555, 4'd7, 1, 1, 1);
    run(1, 16'h00FF, 16'h0000, 4'd8, 1, 0, 1);
    run(0, 16'h0011, 16'h0000, 4'd9, 1, 0, 1);

    // Randomized instruction mix
    for (int i = 0; i < 300; i++)
      run(($urandom_range(0, 7) != 0),
          ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255)),
          16'($urandom), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Load stream with en toggling; upstream advances only on en && !stall
    fork
      begin
        #2;
        repeat (30) begin en = ~en; #15; end
        en = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          a = 16'($urandom_range(0, 255));
          exp_d[i] = mdl[a[7:0]];
          ex_valid = 1; ex_alu_result = a; ex_store_data = '0; ex_rd = 4'(i);
          ex_mem_read = 1; ex_mem_write = 0; ex_reg_write = 1;
          done = 0;
          for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk); #4;
            en_b = en;
            adv  = en && !stall;
            if (!en) chk("en0_stall", stall, 0);
            @(posedge clk); #1;
            if (en_b && wb_valid) begin
              q_data.push_back(wb_data);
              q_rd.push_back(wb_rd);
            end
            if (adv) done = 1;
          end
          if (!done) chk("en_timeout", 0, 1);
        end
      end
    join
    chk("en_result_count", q_data.size(), 8);
    for (int i = 0; i < 8 && i < q_data.size(); i++) begin
      chk("en_wb_data", q_data[i], exp_d[i]);
      chk("en_wb_rd", q_rd[i], 4'(i));
    end

    // Reset asserted while in LOAD
    @(negedge clk);
    ex_valid = 1; ex_alu_result = 16'h0030; ex_rd = 4'd7;
    ex_mem_read = 1; ex_mem_write = 0; ex_reg_write = 1;
    #1 chk("rl_stall", stall, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rl_wb_valid", wb_valid, 0);
    chk("rl_wb_rw", wb_reg_write, 0);
    chk("rl_stall_rst", stall, 0);
    chk("rl_wb_data", wb_data, 0);
    @(negedge clk); ex_valid = 0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1 chk("rl_idle_stall", stall, 0);
    run(1, 16'h0030, 16'h0000, 4'd7, 1, 0, 1);
    run(1, 16'h0042, 16'h0000, 4'd3, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
